dm_responder: RTL and testbench

Multi-cycle data-memory responder answering load/store requests from the pipelined MIPS core's MEM stage over a valid/ready request channel and a one-cycle response pulse. It replaces the zero-latency data memory so the core can be verified against realistic memory latency. The core stalls MEM while `req_ready` is low, or while a load is outstanding and `resp_valid` has not yet pulsed. Storage is 4 KB (1024 words), word-addressed by `req_addr[11:2]`, with byte-enable writes.

---
 rtl/dm_pkg.sv | 13 +
 rtl/dm_ram.sv | 25 ++
 rtl/dm_responder.sv | 125 ++++++++++++
 tb/tb_dm_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and defaults for the data-memory responder.
package dm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int unsigned DM_ADDR_W  = 10;
  localparam int unsigned DM_LATENCY = 2;
  localparam int unsigned CNT_W      = 3;

endpackage

// File: rtl/dm_ram.sv
// Single-port word array: clocked byte-enable write, asynchronous read.
module dm_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dm_responder.sv
// Load/store responder with configurable read latency in front of dm_ram.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W  = DM_ADDR_W,
  parameter int unsigned LATENCY = DM_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic              accept;
  logic              req_err;
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  assign req_idx = req_addr[ADDR_W+1:2];
  assign req_err = (req_be == 4'b1111) && (req_addr[1:0] != 2'b00);
  assign accept  = req_valid && req_ready;
  assign ram_we  = accept && req_we && !req_err;
  // Writes only occur in IDLE, so one address port serves both directions.
  assign ram_addr = (state_q == WAIT) ? idx_q : req_idx;

  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (req_be),
    .wdata_i (req_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) idx_q <= req_idx;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !req_we && !req_err && (LATENCY > 1)) begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we) begin
            resp_valid_d = 1'b1;
          end else if (LATENCY == 1) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ram_rdata;
          end
        end
      end
      WAIT: begin
        if (cnt_q == ONE) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = ram_rdata;
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        v1 = 1'b0, we1 = 1'b0;
  logic [11:0] addr1 = '0;
  logic [31:0] wd1 = '0;
  logic [3:0]  be1 = '0;
  logic        ready1, rv1, err1;
  logic [31:0] rd1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(ready1), .req_we(we1),
    .req_addr(addr1), .req_wdata(wd1), .req_be(be1),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  // Issue one request on the LATENCY=2 instance and wait (bounded) for its pulse.
  task automatic do_req(input vec_t v, output logic err, output logic [31:0] rdata, output int lat);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'b0000;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    err = resp_err;
    rdata = resp_rdata;
  endtask

  vec_t vecs[10];

  initial begin
    logic        e;
    logic [31:0] d;
    int          lat;

    vecs[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        1};
    vecs[1] = '{1'b0, 12'h010, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEF, 2};
    vecs[2] = '{1'b1, 12'h030, 32'h11223344, 4'b1111, 1'b0, 32'h0,        1};
    vecs[3] = '{1'b1, 12'h030, 32'h000000AA, 4'b0001, 1'b0, 32'h0,        1};
    vecs[4] = '{1'b0, 12'h030, 32'h0,        4'b0000, 1'b0, 32'h112233AA, 2};
    vecs[5] = '{1'b1, 12'h010, 32'h55667788, 4'b0000, 1'b0, 32'h0,        1};
    vecs[6] = '{1'b1, 12'h013, 32'h12345678, 4'b1111, 1'b1, 32'h0,        1};
    vecs[7] = '{1'b0, 12'h010, 32'h0,        4'b0000, 1'b0, 32'hDEADBEEF, 2};
    vecs[8] = '{1'b1, 12'hFFC, 32'hA5A5A5A5, 4'b1111, 1'b0, 32'h0,        1};
    vecs[9] = '{1'b1, 12'hFFC, 32'hCAFEF00D, 4'b1100, 1'b0, 32'h0,        1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i], e, d, lat);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Partial upper-half store over a full word
    do_req('{1'b0, 12'hFFC, 32'h0, 4'b0000, 1'b0, 32'h0, 2}, e, d, lat);
    chk("be_upper_rdata", d, 32'hCAFEA5A5);

    // Load holds req_ready low for exactly one cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h030; req_be = 4'b0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_ready_low", {31'b0, req_ready}, 32'd0);
    chk("wait_no_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("wait_ready_back", {31'b0, req_ready}, 32'd1);
    chk("wait_valid", {31'b0, resp_valid}, 32'd1);
    chk("wait_rdata", resp_rdata, 32'h112233AA);
    @(posedge clk); #1;
    chk("pulse_single", {31'b0, resp_valid}, 32'd0);

    // Back-to-back store then load to the same word
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h020; req_wdata = 32'h0BADC0DE; req_be = 4'b1111;
    @(posedge clk); #1;
    chk("b2b_ack", {31'b0, resp_valid}, 32'd1);
    chk("b2b_ack_err", {31'b0, resp_err}, 32'd0);
    chk("b2b_ready_in_ack", {31'b0, req_ready}, 32'd1);
    req_we = 1'b0; req_be = 4'b0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_load_wait", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_load_valid", {31'b0, resp_valid}, 32'd1);
    chk("b2b_load_rdata", resp_rdata, 32'h0BADC0DE);

    // Reset during WAIT drops the in-flight load
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h030;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstw_in_wait", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstw_ready", {31'b0, req_ready}, 32'd1);
    chk("rstw_valid", {31'b0, resp_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rstw_quiet%0d", i), {31'b0, resp_valid}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rstw_post%0d", i), {31'b0, resp_valid}, 32'd0);
    end
    do_req('{1'b0, 12'h020, 32'h0, 4'b0000, 1'b0, 32'h0, 2}, e, d, lat);
    chk("rstw_reload_rdata", d, 32'h0BADC0DE);
    chk("rstw_reload_lat", lat, 32'd2);
    do_req('{1'b0, 12'h010, 32'h0, 4'b0000, 1'b0, 32'h0, 2}, e, d, lat);
    chk("err_store_kept", d, 32'hDEADBEEF);

    // LATENCY=1 instance: continuous stores, then continuous loads
    v1 = 1'b1; we1 = 1'b1; be1 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      addr1 = 12'(i * 4 + 12'h100); wd1 = 32'h1000 + i;
      @(posedge clk); #1;
      chk($sformatf("l1_st%0d_ack", i), {31'b0, rv1}, 32'd1);
      chk($sformatf("l1_st%0d_ready", i), {31'b0, ready1}, 32'd1);
    end
    we1 = 1'b0; be1 = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      addr1 = 12'((3 - i) * 4 + 12'h100);
      @(posedge clk); #1;
      chk($sformatf("l1_ld%0d_valid", i), {31'b0, rv1}, 32'd1);
      chk($sformatf("l1_ld%0d_rdata", i), rd1, 32'h1000 + (3 - i));
      chk($sformatf("l1_ld%0d_ready", i), {31'b0, ready1}, 32'd1);
    end
    v1 = 1'b0;
    @(posedge clk); #1;
    chk("l1_idle", {31'b0, rv1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
